uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, downstream of the `cpu` core. Decodes `ALUResult`, `MemWrite` and `WriteData` from the core. Stores to its register window queue bytes in a small FIFO, which a baud-rate serializer drains as 8N1 frames on `tx`. Reads return status combinationally on `ReadDataMmio`, so a single-cycle load completes in the same cycle. The top-level read mux selects this data when `Hit` is high.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: register window base; 16-byte aligned.
- `CLK_DIV`, default 16: clock cycles per UART bit; ≥2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  — the only clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-low reset.
- `MemWrite`  in  1  — store strobe from the core.
- `ALUResult`  in  32  — byte address from the core.
- `WriteData`  in  32  — store data from the core.
- `ReadDataMmio`  out  32  — combinational read data; 0 when `Hit`=0.
- `Hit`  out  1  — combinational; `ALUResult[31:4]` == `BASE_ADDR[31:4]`.
- `tx`  out  1  — serial output; registered; idle high.
- `busy`  out  1  — registered; 1 when FSM ≠ IDLE.

## Operation
Register map. Offset is `ALUResult[3:2]`; `ALUResult[1:0]` is ignored.
- 0, TXDATA: a write pushes `WriteData[7:0]`. Reads return 0.
- 1, STATUS (read):
  - bit0 full, bit1 empty, bit2 busy.
  - bits[5:3] count, saturating at 7.
  - bit6 overflow, sticky.
  - Writing 1 to bit6 clears it; other written bits are ignored.
- 2, CTRL: bit0 enable, R/W. Other bits read 0.
- 3: reserved. Reads 0; writes ignored.

Push and pop rules:
- A push occurs on a cycle with `MemWrite`=1, `Hit`=1 and offset 0.
- Push while full (count == `FIFO_DEPTH`) with no pop in the same cycle: the byte is dropped and overflow is set.
- Push and pop in the same cycle: both take effect, count is unchanged, and the push is never dropped.
- Writes while enable=0 still queue. Only serialization is gated by enable.

FSM states:
- IDLE: `tx`=1. If enable=1 and FIFO non-empty, pop the head into the shift register, load the baud counter, and go to START.
- START: `tx`=0 for `CLK_DIV` cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0] for `CLK_DIV` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
- STOP: `tx`=1 for `CLK_DIV` cycles. On the final cycle:
  - if enable=1 and FIFO non-empty, pop and go directly to START, so there is no idle gap;
  - otherwise go to IDLE.

Baud counter and frame length:
- The baud counter counts down from `CLK_DIV`-1 to 0. The state or bit advances when the counter is 0.
- A frame is exactly 10·`CLK_DIV` cycles.

Clearing enable mid-frame: the current frame completes; no further pop occurs.

Reset (`reset`=0 at a clock edge, including mid-frame):
- FIFO emptied; overflow=0; enable=0.
- FSM=IDLE, `tx`=1, `busy`=0, counters 0. All take effect on that edge.

## Timing
- Write to TXDATA at edge E0 with the FIFO empty, FSM IDLE and enable=1: the byte is visible after E0; the FSM pops at E1; `tx` falls after E1. Latency from the write edge is 1 cycle.
- Enable set at edge E0 with the FIFO already non-empty: `tx` falls after E1.
- STATUS and CTRL reads reflect register state before the current edge. A read in the same cycle as a push shows the pre-push count.
- `Hit` and `ReadDataMmio` are purely combinational from `ALUResult`.
- `tx` and `busy` are registers; there is no combinational path from the bus to them.

## Structure
- Package `uart_mmio_pkg`:
  - register offset constants (TXDATA=0, STATUS=1, CTRL=2);
  - STATUS bit indices;
  - FSM state enum (IDLE, START, DATA, STOP).
- Sub-module `tx_fifo`: synchronous FIFO.
  - Parameter `DEPTH`; width 8.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Read-before-write semantics for simultaneous push and pop.
  - Same `clk` and `reset` as the parent.
- Top-level contents: address decode, CTRL/overflow registers, baud counter, FSM.

## Test plan
- Reset, then enable=1, then store 8'hA5 to TXDATA, with `CLK_DIV`=4:
  - `tx` falls 1 cycle after the write edge;
  - `tx` holds for 4 cycles per bit;
  - bit sequence is 0,1,0,1,0,0,1,0,1,1;
  - `busy` drops after 40 cycles.
- Enable=0, store 5 bytes:
  - STATUS reads full=1, count=4, overflow=1;
  - write 1 to bit6 clears overflow;
  - set enable=1: 4 frames go out back-to-back with no idle cycle between stop and start.
- FIFO full during transmission, push coincides with a pop at the STOP→START boundary: push accepted, overflow stays 0, count stays 4.
- Clear enable mid-DATA: the frame completes; the next queued byte is not popped; STATUS empty=0, busy=0.
- Assert `reset` mid-frame: on the next edge `tx`=1, `busy`=0, STATUS reads empty=1 and count=0, CTRL reads 0.
- Address handling:
  - read at `BASE_ADDR`+12 returns 0 with `Hit`=1;
  - store at `BASE_ADDR`+16 gives `Hit`=0, no push, `ReadDataMmio`=0.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the serializer state encoding.
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_CNT_LSB = 3;
  localparam int ST_CNT_MSB = 5;
  localparam int ST_OVF     = 6;

  localparam int CTRL_EN = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide synchronous FIFO with combinational head output; a simultaneous
// push and pop is accepted even when full because the head is read first.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, CTRL/overflow registers,
// TX FIFO and a baud-rate serializer that drains it frame by frame.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadDataMmio,
  output logic        Hit,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  function automatic logic [2:0] sat_count(input logic [CW-1:0] c);
    logic [31:0] w_c;
    w_c = 32'(c);
    return (w_c > 32'd7) ? 3'd7 : w_c[2:0];
  endfunction

  logic [1:0]    w_off;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_clr;
  logic [7:0]    w_dout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused_bits;

  logic          r_enable;
  logic          r_ovf;
  tx_state_e     r_state;
  tx_state_e     w_state_n;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic          r_tx;
  logic          w_tx_n;
  logic          r_busy;

  assign Hit       = (ALUResult[31:4] == BASE_ADDR[31:4]);
  assign w_off     = ALUResult[3:2];
  assign w_wr      = MemWrite & Hit;
  assign w_push    = w_wr & (w_off == OFF_TXDATA);
  assign w_ovf_clr = w_wr & (w_off == OFF_STATUS) & WriteData[ST_OVF];

  assign w_unused_bits = ^{WriteData[31:8], ALUResult[1:0]};

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (WriteData[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_status                        = '0;
    w_status[ST_FULL]               = w_full;
    w_status[ST_EMPTY]              = w_empty;
    w_status[ST_BUSY]               = r_busy;
    w_status[ST_CNT_MSB:ST_CNT_LSB] = sat_count(w_count);
    w_status[ST_OVF]                = r_ovf;
  end

  always_comb begin
    w_rdata = '0;
    if (Hit) begin
      case (w_off)
        OFF_STATUS: w_rdata = w_status;
        OFF_CTRL:   w_rdata = {31'd0, r_enable};
        default:    w_rdata = '0;
      endcase
    end
  end

  assign ReadDataMmio = w_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable <= 1'b0;
    end else if (w_wr && (w_off == OFF_CTRL)) begin
      r_enable <= WriteData[CTRL_EN];
    end
  end

  // A dropped push in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_enable && !w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_dout;
          w_baud_n  = BAUD_LOAD;
          w_state_n = START;
        end
      end
      START: begin
        if (r_baud == '0) begin
          w_baud_n  = BAUD_LOAD;
          w_bit_n   = 3'd0;
          w_state_n = DATA;
        end else begin
          w_baud_n = r_baud - 1'b1;
        end
      end
      DATA: begin
        if (r_baud == '0) begin
          w_baud_n  = BAUD_LOAD;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_n = STOP;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end else begin
          w_baud_n = r_baud - 1'b1;
        end
      end
      STOP: begin
        if (r_baud == '0) begin
          if (r_enable && !w_empty) begin
            // Chain straight into the next frame with no idle bit.
            w_pop     = 1'b1;
            w_shift_n = w_dout;
            w_baud_n  = BAUD_LOAD;
            w_state_n = START;
          end else begin
            w_baud_n  = '0;
            w_state_n = IDLE;
          end
        end else begin
          w_baud_n = r_baud - 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase

    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_tx    <= w_tx_n;
      r_busy  <= (w_state_n != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_n;
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: expected frames and read data are queued
// by the stimulus and consumed by independent frame and read monitors.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE + 32'd0;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_CT = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadDataMmio;
  logic        Hit;
  logic        tx;
  logic        busy;

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadDataMmio (ReadDataMmio),
    .Hit          (Hit),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_start;
    bit         b2b;
    bit         chk_idle;
  } frm_t;

  frm_t        frm_q[$];
  string       rd_nm_q[$];
  logic [31:0] rd_dat_q[$];
  logic        rd_hit_q[$];
  logic        rd_vld = 1'b0;
  bit          mon_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int e0);
    ALUResult = a;
    WriteData = d;
    MemWrite  = 1'b1;
    step();
    e0        = cyc;
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] d, input logic h);
    ALUResult = a;
    MemWrite  = 1'b0;
    rd_nm_q.push_back(nm);
    rd_dat_q.push_back(d);
    rd_hit_q.push_back(h);
    rd_vld = 1'b1;
    step();
    rd_vld = 1'b0;
  endtask

  string       m_nm;
  logic [31:0] m_dat;
  logic        m_hit;
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_nm_q.size() == 0) begin
        n_chk++;
        $display("FAIL read_queue: got empty queue expected an entry");
      end else begin
        m_nm  = rd_nm_q.pop_front();
        m_dat = rd_dat_q.pop_front();
        m_hit = rd_hit_q.pop_front();
        chk({m_nm, "_data"}, ReadDataMmio, m_dat);
        chk({m_nm, "_hit"}, {31'd0, Hit}, {31'd0, m_hit});
      end
    end
  end

  initial begin : frame_mon
    frm_t        e;
    int          start;
    int          prev_end;
    logic [39:0] smp;
    logic [9:0]  bits;
    bit          hold_ok;
    bit          busy_ok;
    bit          have;
    prev_end = -100;
    have     = 1'b0;
    forever begin
      if (!have) @(negedge clk);
      have = 1'b0;
      if (!mon_en || tx !== 1'b0) continue;
      start   = cyc;
      busy_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (i != 0) @(negedge clk);
        smp[i] = tx;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      hold_ok = 1'b1;
      for (int g = 0; g < 10; g++) begin
        bits[g] = smp[4*g];
        for (int k = 1; k < 4; k++) if (smp[4*g+k] !== smp[4*g]) hold_ok = 1'b0;
      end
      e.chk_idle = 1'b0;
      if (frm_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_frame: got byte %h expected no frame (start cycle %0d)", bits[8:1], start);
      end else begin
        e = frm_q.pop_front();
        chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
        chk("start_bit", {31'd0, bits[0]}, 32'd0);
        chk("stop_bit", {31'd0, bits[9]}, 32'd1);
        chk("bit_hold", {31'd0, hold_ok}, 32'd1);
        chk("frame_busy", {31'd0, busy_ok}, 32'd1);
        if (e.exp_start >= 0) chk("start_cycle", start, e.exp_start);
        if (e.b2b) chk("b2b_gap", start, prev_end + 1);
      end
      prev_end = cyc;
      @(negedge clk);
      have = 1'b1;
      if (e.chk_idle) begin
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_tx", {31'd0, tx}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish before cycle 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    repeat (3) step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    rd("rst_status", A_ST, 32'h02, 1'b1);
    rd("rst_ctrl", A_CT, 32'h00, 1'b1);

    // Single frame: 0xA5 starts one cycle after the write edge.
    wr(A_CT, 32'h1, e);
    rd("ctrl_en", A_CT, 32'h01, 1'b1);
    wr(A_TX, 32'hA5, e);
    frm_q.push_back('{8'hA5, e + 1, 1'b0, 1'b1});
    idle_until(e + 45);

    // Fill while disabled, overflow, clear, then four chained frames.
    wr(A_CT, 32'h0, e);
    wr(A_TX, 32'h11, e);
    wr(A_TX, 32'h22, e);
    wr(A_TX, 32'h33, e);
    wr(A_TX, 32'h44, e);
    wr(A_TX, 32'h55, e);
    rd("ovf_status", A_ST, 32'h61, 1'b1);
    wr(A_ST, 32'h40, e);
    rd("ovf_cleared", A_ST, 32'h21, 1'b1);
    wr(A_CT, 32'h1, e);
    frm_q.push_back('{8'h11, e + 1, 1'b0, 1'b0});
    frm_q.push_back('{8'h22, -1, 1'b1, 1'b0});
    frm_q.push_back('{8'h33, -1, 1'b1, 1'b0});
    frm_q.push_back('{8'h44, -1, 1'b1, 1'b1});
    idle_until(e + 170);

    // Push coinciding with the STOP->START pop while full.
    wr(A_CT, 32'h0, e);
    wr(A_TX, 32'h01, e);
    wr(A_TX, 32'h02, e);
    wr(A_TX, 32'h03, e);
    wr(A_CT, 32'h1, e);
    frm_q.push_back('{8'h01, e + 1, 1'b0, 1'b0});
    frm_q.push_back('{8'h02, -1, 1'b1, 1'b0});
    frm_q.push_back('{8'h03, -1, 1'b1, 1'b0});
    frm_q.push_back('{8'h04, -1, 1'b1, 1'b0});
    frm_q.push_back('{8'h05, -1, 1'b1, 1'b0});
    frm_q.push_back('{8'h06, -1, 1'b1, 1'b1});
    begin
      int e_en;
      int tmp;
      e_en = e;
      wr(A_TX, 32'h04, tmp);
      wr(A_TX, 32'h05, tmp);
      idle_until(e_en + 20);
      rd("full_busy_status", A_ST, 32'h25, 1'b1);
      idle_until(e_en + 40);
      wr(A_TX, 32'h06, tmp);
      chk("boundary_push_edge", tmp, e_en + 41);
      rd("boundary_status", A_ST, 32'h25, 1'b1);
      idle_until(e_en + 250);
    end

    // Clearing enable mid-DATA finishes the frame and leaves 0x5A queued.
    wr(A_CT, 32'h0, e);
    wr(A_TX, 32'h3C, e);
    wr(A_TX, 32'h5A, e);
    wr(A_CT, 32'h1, e);
    frm_q.push_back('{8'h3C, e + 1, 1'b0, 1'b1});
    begin
      int e_en;
      int tmp;
      e_en = e;
      idle_until(e_en + 12);
      wr(A_CT, 32'h0, tmp);
      idle_until(e_en + 50);
    end
    rd("disable_status", A_ST, 32'h08, 1'b1);
    rd("disable_ctrl", A_CT, 32'h00, 1'b1);

    // Reset in the middle of the 0x5A frame.
    mon_en = 1'b0;
    wr(A_CT, 32'h1, e);
    idle_until(e + 15);
    reset = 1'b0;
    step();
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    rd("midrst_status", A_ST, 32'h02, 1'b1);
    rd("midrst_ctrl", A_CT, 32'h00, 1'b1);
    mon_en = 1'b1;

    // Address window handling.
    rd("reserved", BASE + 32'd12, 32'h0, 1'b1);
    rd("txdata_read", A_TX, 32'h0, 1'b1);
    wr(BASE + 32'd16, 32'h77, e);
    rd("out_of_window", BASE + 32'd16, 32'h0, 1'b0);
    rd("status_lowbits", BASE + 32'd7, 32'h02, 1'b1);
    repeat (5) step();

    chk("frames_left", frm_q.size(), 32'd0);
    chk("reads_left", rd_nm_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
